// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RF   = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_BLOCK_W = 128;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: returns the lowest requesting index at or above ptr_i, wrapping.
// Purely combinational; no backpressure.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   win_o,
    output logic               any_o
);

    always_comb begin
        int idx;
        idx   = 0;
        win_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                win_o = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to one cache controller for a whole miss (write-back then refill),
// one cycle after the request is seen in IDLE; responses are routed combinationally to the owner only.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_rd,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ-1:0]               req_rdy,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][BLOCK_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               req_mem_ready,
    output logic [NUM_REQ-1:0]               req_mem_valid,
    output logic [BLOCK_W-1:0]               req_rdata,
    output logic                             mem_read_en,
    output logic                             mem_write_en,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [BLOCK_W-1:0]               mem_wdata,
    output logic                             mem_ready_cache,
    input  logic                             mem_ready,
    input  logic                             mem_valid,
    input  logic [BLOCK_W-1:0]               mem_rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t       state_q, state_d;
    logic [PTR_W-1:0] g_q, g_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win;
    logic             any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i (req_rd | req_wr),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    g_d     = win;
                    state_d = req_wr[win] ? WB : RF;
                end
            end
            WB: begin
                if (req_wr[g_q] && mem_ready) begin
                    state_d = RF;
                end
            end
            RF: begin
                if (mem_valid && req_rdy[g_q]) begin
                    state_d = IDLE;
                    // Explicit wrap: NUM_REQ need not be a power of two.
                    ptr_d   = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_rdata = mem_rdata;

    always_comb begin
        gnt             = '0;
        req_mem_ready   = '0;
        req_mem_valid   = '0;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_ready_cache = 1'b0;
        mem_addr        = req_addr[0];
        mem_wdata       = req_wdata[0];
        if (state_q != IDLE) begin
            gnt[g_q]           = 1'b1;
            req_mem_ready[g_q] = mem_ready;
            req_mem_valid[g_q] = mem_valid;
            mem_addr           = req_addr[g_q];
            mem_wdata          = req_wdata[g_q];
            mem_ready_cache    = req_rdy[g_q];
            mem_write_en       = (state_q == WB) && req_wr[g_q] && mem_ready;
            mem_read_en        = (state_q == RF) && req_rd[g_q];
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single main-memory port between NUM_REQ cache controllers (e.g. I-cache and D-cache). Each controller drives its usual memory-side ready/valid handshake. The arbiter grants one controller at a time and holds that grant for a whole miss transaction: an optional write-back beat, then the refill beat. It then rotates priority round-robin. It sits between the cache controllers' memory interfaces and the main-memory model.

## Interface
- NUM_REQ, 2, number of requesting cache controllers (≥2)
- ADDR_W, 32, block address width
- BLOCK_W, 128, cache block (beat) width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_rd  in  NUM_REQ  per-requester read_en_mem (refill request)
- req_wr  in  NUM_REQ  per-requester write-back valid (valid_cache & write_en_mem)
- req_rdy  in  NUM_REQ  per-requester ready_cache (ready to accept refill)
- req_addr  in  NUM_REQ×ADDR_W  per-requester block address
- req_wdata  in  NUM_REQ×BLOCK_W  per-requester write-back data
- gnt  out  NUM_REQ  one-hot grant
- req_mem_ready  out  NUM_REQ  ready_mem routed to granted requester only
- req_mem_valid  out  NUM_REQ  valid_mem routed to granted requester only
- req_rdata  out  BLOCK_W  mem_rdata broadcast to all requesters
- mem_read_en  out  1  read strobe to memory
- mem_write_en  out  1  write strobe to memory
- mem_addr  out  ADDR_W  muxed address
- mem_wdata  out  BLOCK_W  muxed write data
- mem_ready_cache  out  1  granted requester's req_rdy
- mem_ready  in  1  memory accepts write beat
- mem_valid  in  1  memory presents refill data
- mem_rdata  in  BLOCK_W  refill data

## Operation
- FSM states: IDLE, WB (write-back phase), RF (refill phase).
- IDLE, any req_rd|req_wr asserted: pick the winner g by round-robin, scanning from ptr upward with wrap. Register g. Go to WB if req_wr[g], else RF.
- WB: complete when req_wr[g] && mem_ready, then go to RF.
- RF: complete when mem_valid && req_rdy[g], then go to IDLE and set ptr ← (g+1) mod NUM_REQ.
- Grant is held across WB→RF. Requests from other requesters are ignored until return to IDLE.
- Deassertion of the granted requester's request mid-transaction does not release the grant. The FSM holds state, and memory strobes follow the requester's current signals.
- Datapath in WB/RF: mem_addr/mem_wdata = req_addr[g]/req_wdata[g]. mem_write_en = req_wr[g] && mem_ready && state==WB. mem_read_en = req_rd[g] && state==RF. mem_ready_cache = req_rdy[g].
- Non-granted requesters see gnt=0, req_mem_ready=0, req_mem_valid=0.
- In IDLE all memory strobes are 0. mem_addr/mem_wdata hold requester 0's values (don't-care to memory).
- ptr is $clog2(NUM_REQ) bits and wraps modulo NUM_REQ. This is not a power-of-two wrap when NUM_REQ is not a power of two.

## Timing
- Reset, rst_n low at clk edge: state=IDLE, g=0, ptr=0. All strobes, gnt, req_mem_ready and req_mem_valid read 0 from the cycle after the reset edge. Reset mid-transaction aborts it with no completion signalled.
- Arbitration latency: a request seen in IDLE at edge N gives gnt valid during cycle N+1.
- Routing is combinational in WB/RF: memory responses reach the granted requester in the same cycle.
- After RF completes there is one IDLE cycle before the next grant. Minimum transaction is 3 cycles (IDLE, RF, IDLE).
- Simultaneous requests in IDLE: the lowest index ≥ ptr wins. Equal treatment follows from rotation.
- mem_ready and mem_valid are both high in RF: only mem_valid matters. In WB only mem_ready matters.

## Structure
- Package mem_arb_pkg: arb_state_t enum (IDLE, WB, RF) and the default width localparams.
- Sub-module rr_pick: combinational round-robin selector taking req vector and ptr, returning winner index and any_req.
- Top holds FSM, g/ptr registers, and the muxes. Expected size is about 150–250 lines.

## Test plan
- Single read miss: req_rd[0]=1 at cycle 0 → gnt=01 in cycle 1, mem_read_en=1. mem_valid with req_rdy[0] at cycle 3 → req_mem_valid[0]=1 that cycle, IDLE at cycle 4, ptr=1.
- Dirty miss: req_wr[1]=req_rd[1]=1 with mem_ready delayed 2 cycles → grant 10 held through WB and RF. mem_write_en pulses once and mem_read_en follows. Requester 0 asserts meanwhile and is not granted until after RF completes.
- Contention fairness: both requesters assert continuously, each completing in 1 RF beat → grant sequence 01,10,01,10 starting from ptr=0.
- NUM_REQ=3, ptr=2: requests from 0 and 1 only → 0 wins (wrap), ptr becomes 1.
- Reset mid-WB: rst_n=0 while in WB with mem_ready=0 → next cycle state IDLE, gnt=0, mem_write_en=0, ptr=0.
- Isolation: during requester 0's RF, mem_valid=1 → req_mem_valid[1] stays 0 and req_rdata still equals mem_rdata.
